alu_wb: RTL
===========

Name: alu_wb

Overview:
- Execute/writeback stage that feeds the 5-entry CPU register file (A, X, Y, SP, P).
- Accepts one decoded ALU op from decode via valid/ready.
- Uses the register file's single combinational read/write port to fetch operands and P, compute the result and new flags, then write the result and P back.
- Multi-cycle FSM; one op in flight.

Parameters:
- none. Widths come from package constants (`BYTE = 8; register file data = 2*`BYTE).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- op_valid_i  in  1  decode presents op
- op_ready_o  out  1  stage idle, can accept
- op_i  in  4  alu_op_t
- dst_reg_i  in  3  reg_id_t; destination and operand A
- src_reg_i  in  3  reg_id_t; operand B when use_imm_i=0
- imm_i  in  8  immediate operand B
- use_imm_i  in  1  select imm_i as operand B
- done_o  out  1  one-cycle pulse, op fully retired
- reg_addr_o  out  3  register file address
- reg_we_o  out  1  register file write enable
- reg_data_o  out  16  write data, zero-extended byte
- reg_read_data_i  in  16  register file read data; only bits [7:0] used

Behaviour:
- Reset (async, any state): FSM→IDLE; op_ready_o=0 while rstn_i low; reg_we_o=0, reg_addr_o=0, reg_data_o=0, done_o=0; latched operands cleared. An in-flight op is dropped with no partial P write.
- States: IDLE, RD_A, RD_B, RD_P, WB_R, WB_P.
- IDLE:
  - op_ready_o=1.
  - On op_valid_i&&op_ready_o, latch op/dst/src/imm/use_imm, then go to RD_A.
- RD_A: reg_addr_o=dst; latch A=reg_read_data_i[7:0].
  - Next state is RD_P if use_imm_i or op is unary (ASL, LSR, ROL, ROR, INC, DEC).
  - Otherwise next state is RD_B.
- RD_B: reg_addr_o=src; latch B. Next state RD_P.
- RD_P: reg_addr_o=REG_P; latch P. Next state is WB_P for CMP, otherwise WB_R.
- WB_R: reg_we_o=1, reg_addr_o=dst, reg_data_o={8'h00,result}. Next state WB_P.
- WB_P:
  - reg_we_o=1, reg_addr_o=REG_P, reg_data_o={8'h00,newP}; done_o=1.
  - If the op is TRN with dst=REG_SP: reg_we_o=0, P unchanged, done_o still 1.
  - Next state IDLE.
- Latency, valid accept in cycle 0:
  - Binary op: done_o in cycle 5.
  - Immediate or unary op: cycle 4.
  - CMP: one fewer cycle than the matching case.
  - Back-to-back accept in the cycle after done_o.
- Operand B is ignored for unary ops.
- P bits: C=0, Z=1, I=2, D=3, B=4, V=6, N=7. Only N, V, Z, C are modified; I, D, B and bit 5 pass through.
- ADC: {C,r} = A+B+C. V = (A[7]==B[7]) && (r[7]!=A[7]).
- SBC: ADC with ~B.
- AND, ORA, EOR: bitwise.
- ASL, LSR: C = shifted-out bit; 0 fills the vacated bit.
- ROL, ROR: old C fills; C = shifted-out bit.
- INC, DEC: wrap mod 256; C, V unchanged.
- CMP: {C,r} = A + ~B + 1; set N, Z, C; no result write.
- TRN: r = B; set N, Z.
- N = r[7]; Z = (r==0) for every flag-setting op.
- op_valid_i is ignored outside IDLE.
- A write to REG_P as dst: the WB_P write wins; final P = computed flags.

Optional Feature:
- ALU_DECIMAL_EN: compiled in, ADC/SBC apply BCD adjust when latched P.D=1.
  - Per-nibble correction is +6/−6.
  - C = decimal carry/borrow.
  - N, V, Z are taken from the binary result.
- Without the macro, P.D is ignored (2A03 behaviour); pure binary arithmetic.

Decomposition:
- Shared package (cpu_pkg) holds:
  - `BYTE.
  - reg_id_t enum: REG_A=0, REG_X=1, REG_Y=2, REG_SP=3, REG_P=4.
  - alu_op_t enum: ADC, SBC, AND, ORA, EOR, ASL, LSR, ROL, ROR, INC, DEC, CMP, TRN.
  - P bit-index localparams.
  - alu_state_t.
- One natural sub-module, alu_core: purely combinational; (op, A, B, P) → (result, newP). Unit-testable standalone.
- alu_wb keeps the FSM, latches and register file port muxing.

Test Plan:
- ADC A=0x50, imm 0x50, P=0x00 → A=0xA0; P: N=1, V=1, Z=0, C=0; done_o in cycle 4.
- SBC A=0x00, imm 0x01, P.C=1 → A=0xFF; N=1, C=0, V=0, Z=0.
- CMP X=0x10 vs Y=0x10 (register mode) → no write to X; P gets Z=1, C=1, N=0; exactly one reg_we_o pulse, done_o in cycle 4.
- ROR A=0x01, P.C=1 → A=0x80; C=1, N=1.
- TRN dst=SP, src=X=0x3C → SP=0x3C, P write suppressed, done_o asserted.
- ADC A=0x09, imm 0x01, P.D=1 → 0x10 with ALU_DECIMAL_EN, 0x0A without.
- Mid-op reset: rstn_i low in RD_P → no reg_we_o, op_ready_o=0 during reset, IDLE with op_ready_o=1 one cycle after release; register file contents unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: byte width, register ids, ALU opcodes, P flag bit positions
// and the execute/writeback state encoding.
`ifndef BYTE
`define BYTE 8
`endif

package cpu_pkg;
  localparam int BYTE_W = `BYTE;
  localparam int DATA_W = 2 * `BYTE;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_X  = 3'd1,
    REG_Y  = 3'd2,
    REG_SP = 3'd3,
    REG_P  = 3'd4
  } reg_id_t;

  typedef enum logic [3:0] {
    ADC = 4'd0,
    SBC = 4'd1,
    AND = 4'd2,
    ORA = 4'd3,
    EOR = 4'd4,
    ASL = 4'd5,
    LSR = 4'd6,
    ROL = 4'd7,
    ROR = 4'd8,
    INC = 4'd9,
    DEC = 4'd10,
    CMP = 4'd11,
    TRN = 4'd12
  } alu_op_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_V = 6;
  localparam int P_N = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_RD_P = 3'd3,
    S_WB_R = 3'd4,
    S_WB_P = 3'd5
  } alu_state_t;

  // Unary ops never fetch operand B.
  function automatic logic is_unary(alu_op_t op);
    return (op inside {ASL, LSR, ROL, ROR, INC, DEC});
  endfunction
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (op, A, B, P) -> (result, new P); only N, V, Z, C change.
// ALU_DECIMAL_EN adds BCD adjust to ADC/SBC when P.D is set; without it P.D is ignored.
module alu_core
  import cpu_pkg::*;
(
  input  alu_op_t           op_i,
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic [BYTE_W-1:0] p_i,
  output logic [BYTE_W-1:0] result_o,
  output logic [BYTE_W-1:0] p_o
);
  logic              w_sub;
  logic [BYTE_W-1:0] w_b_eff;
  logic              w_cin;
  logic [BYTE_W:0]   w_sum;
  logic [BYTE_W-1:0] w_bin;
  logic              w_c;
  logic              w_v;
  logic              w_c_fin;

  // SBC and CMP share the adder as A + ~B + carry-in.
  assign w_sub   = (op_i == SBC) || (op_i == CMP);
  assign w_b_eff = w_sub ? ~b_i : b_i;
  assign w_cin   = (op_i == CMP) ? 1'b1 : p_i[P_C];
  assign w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {{BYTE_W{1'b0}}, w_cin};

  always_comb begin
    w_bin = a_i;
    w_c   = p_i[P_C];
    w_v   = p_i[P_V];
    case (op_i)
      ADC, SBC: begin
        w_bin = w_sum[BYTE_W-1:0];
        w_c   = w_sum[BYTE_W];
        w_v   = (a_i[BYTE_W-1] == w_b_eff[BYTE_W-1]) && (w_sum[BYTE_W-1] != a_i[BYTE_W-1]);
      end
      CMP: begin
        w_bin = w_sum[BYTE_W-1:0];
        w_c   = w_sum[BYTE_W];
      end
      AND: w_bin = a_i & b_i;
      ORA: w_bin = a_i | b_i;
      EOR: w_bin = a_i ^ b_i;
      ASL: begin w_bin = {a_i[BYTE_W-2:0], 1'b0};     w_c = a_i[BYTE_W-1]; end
      LSR: begin w_bin = {1'b0, a_i[BYTE_W-1:1]};     w_c = a_i[0];        end
      ROL: begin w_bin = {a_i[BYTE_W-2:0], p_i[P_C]}; w_c = a_i[BYTE_W-1]; end
      ROR: begin w_bin = {p_i[P_C], a_i[BYTE_W-1:1]}; w_c = a_i[0];        end
      INC: w_bin = a_i + 1'b1;
      DEC: w_bin = a_i - 1'b1;
      TRN: w_bin = b_i;
      default: w_bin = a_i;
    endcase
  end

`ifdef ALU_DECIMAL_EN
  logic [4:0] w_lo_raw;
  logic [4:0] w_hi_raw;
  logic       w_lo_c;
  logic       w_hi_c;
  logic [3:0] w_lo_d;
  logic [3:0] w_hi_d;

  // w_lo_c/w_hi_c are nibble borrows for SBC and nibble carries for ADC.
  always_comb begin
    if (op_i == SBC) begin
      w_lo_raw = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'd0, ~p_i[P_C]};
      w_lo_c   = w_lo_raw[4];
      w_lo_d   = w_lo_c ? (w_lo_raw[3:0] - 4'd6) : w_lo_raw[3:0];
      w_hi_raw = {1'b0, a_i[7:4]} - {1'b0, b_i[7:4]} - {4'd0, w_lo_c};
      w_hi_c   = w_hi_raw[4];
      w_hi_d   = w_hi_c ? (w_hi_raw[3:0] - 4'd6) : w_hi_raw[3:0];
    end else begin
      w_lo_raw = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'd0, p_i[P_C]};
      w_lo_c   = (w_lo_raw > 5'd9);
      w_lo_d   = w_lo_c ? (w_lo_raw[3:0] + 4'd6) : w_lo_raw[3:0];
      w_hi_raw = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + {4'd0, w_lo_c};
      w_hi_c   = (w_hi_raw > 5'd9);
      w_hi_d   = w_hi_c ? (w_hi_raw[3:0] + 4'd6) : w_hi_raw[3:0];
    end
  end
`endif

  always_comb begin
    result_o = w_bin;
    w_c_fin  = w_c;
`ifdef ALU_DECIMAL_EN
    if (((op_i == ADC) || (op_i == SBC)) && p_i[P_D]) begin
      result_o = {w_hi_d, w_lo_d};
      w_c_fin  = (op_i == SBC) ? ~w_hi_c : w_hi_c;
    end
`endif
    // N, V, Z always follow the binary result.
    p_o      = p_i;
    p_o[P_C] = w_c_fin;
    p_o[P_V] = w_v;
    p_o[P_N] = w_bin[BYTE_W-1];
    p_o[P_Z] = (w_bin == '0);
  end
endmodule

// File: rtl/alu_wb.sv
// Execute/writeback stage: fetches A, B and P over the register file's single port,
// runs alu_core, then writes the result and P back. Build option: ALU_DECIMAL_EN.
module alu_wb
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [3:0]        op_i,
  input  logic [2:0]        dst_reg_i,
  input  logic [2:0]        src_reg_i,
  input  logic [BYTE_W-1:0] imm_i,
  input  logic              use_imm_i,
  output logic              done_o,
  output logic [2:0]        reg_addr_o,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_data_o,
  input  logic [DATA_W-1:0] reg_read_data_i
);
  alu_state_t        r_state;
  alu_state_t        w_state_nxt;
  logic              r_rst_done;
  alu_op_t           r_op;
  logic [2:0]        r_dst;
  logic [2:0]        r_src;
  logic              r_use_imm;
  logic [BYTE_W-1:0] r_a;
  logic [BYTE_W-1:0] r_b;
  logic [BYTE_W-1:0] r_p;
  logic [BYTE_W-1:0] w_result;
  logic [BYTE_W-1:0] w_new_p;
  logic [BYTE_W-1:0] w_rd_byte;
  logic              w_unused_hi;
  logic              w_accept;

  assign w_rd_byte   = reg_read_data_i[BYTE_W-1:0];
  assign w_unused_hi = ^reg_read_data_i[DATA_W-1:BYTE_W];

  // Handshake: an op transfers on a clock edge where op_valid_i && op_ready_o; ready is
  // high only in IDLE (and not before the first edge after reset), so valid is ignored
  // while an op is in flight and decode must hold its fields until the transfer edge.
  assign w_accept = (r_state == S_IDLE) && r_rst_done && op_valid_i;

  alu_core u_core (
    .op_i     (r_op),
    .a_i      (r_a),
    .b_i      (r_b),
    .p_i      (r_p),
    .result_o (w_result),
    .p_o      (w_new_p)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_rst_done <= 1'b0;
      r_op       <= ADC;
      r_dst      <= '0;
      r_src      <= '0;
      r_use_imm  <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_p        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op      <= alu_op_t'(op_i);
          r_dst     <= dst_reg_i;
          r_src     <= src_reg_i;
          r_use_imm <= use_imm_i;
          r_b       <= imm_i;  // replaced in RD_B for register-mode ops
        end
        S_RD_A:  r_a <= w_rd_byte;
        S_RD_B:  r_b <= w_rd_byte;
        S_RD_P:  r_p <= w_rd_byte;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    op_ready_o  = 1'b0;
    done_o      = 1'b0;
    reg_we_o    = 1'b0;
    reg_addr_o  = '0;
    reg_data_o  = '0;
    case (r_state)
      S_IDLE: begin
        op_ready_o = r_rst_done;
        if (w_accept) w_state_nxt = S_RD_A;
      end
      S_RD_A: begin
        reg_addr_o  = r_dst;
        w_state_nxt = (r_use_imm || is_unary(r_op)) ? S_RD_P : S_RD_B;
      end
      S_RD_B: begin
        reg_addr_o  = r_src;
        w_state_nxt = S_RD_P;
      end
      S_RD_P: begin
        reg_addr_o  = REG_P;
        w_state_nxt = (r_op == CMP) ? S_WB_P : S_WB_R;
      end
      S_WB_R: begin
        reg_we_o    = 1'b1;
        reg_addr_o  = r_dst;
        reg_data_o  = {{(DATA_W-BYTE_W){1'b0}}, w_result};
        w_state_nxt = S_WB_P;
      end
      S_WB_P: begin
        // A transfer into SP leaves P untouched.
        reg_we_o    = !((r_op == TRN) && (r_dst == REG_SP));
        reg_addr_o  = REG_P;
        reg_data_o  = {{(DATA_W-BYTE_W){1'b0}}, w_new_p};
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule
